// File: rtl/mc_ctrl.sv
// mc_ctrl: main control FSM for the multi-cycle MIPS CPU.
// It sequences fetch, decode, execute, memory access and write-back for each
// instruction. It drives the ALU opcode, the datapath mux selects and every
// write enable, and it counts retired instructions.
module mc_ctrl #(
  parameter int         RETIRE_W = 32,
  parameter logic [4:0] REG_RA   = 5'd31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                overflow,
  output logic                pc_wr,
  output logic                ir_wr,
  output logic                reg_wr,
  output logic                dm_wr,
  output logic [1:0]          alu_ctr,
  output logic                alu_srcb,
  output logic                ext_op,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wd_sel,
  output logic [1:0]          npc_sel,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_EXE = 4'd2,
    S_MA  = 4'd3,
    S_MR  = 4'd4,
    S_MW  = 4'd5,
    S_WB  = 4'd6,
    S_BR  = 4'd7,
    S_JMP = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_ADDI,
    I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // jal's destination register is hardwired in the reg_dst=10 datapath mux,
  // so REG_RA only documents which register that is.
  if (REG_RA != 5'd31) begin : g_reg_ra_is_informational
  end

  state_t state_q;
  state_t state_d;
  instr_t instr;
  logic   retire;
  logic   is_rtype_alu;

  // Decode the latched IR fields into one instruction class.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first; a
    // path that skips an assignment would otherwise infer a latch.
    instr = I_BAD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_SLT:  instr = I_SLT;
          FN_JR:   instr = I_JR;
          default: instr = I_BAD;
        endcase
      end
      OP_ORI:  instr = I_ORI;
      OP_ADDI: instr = I_ADDI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      OP_BEQ:  instr = I_BEQ;
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      default: instr = I_BAD;
    endcase
  end

  assign is_rtype_alu = (instr == I_ADDU) || (instr == I_SUBU) || (instr == I_SLT);

  // Next-state and datapath control outputs for the current state.
  always_comb begin
    state_d  = S_IF;
    retire   = 1'b0;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    dm_wr    = 1'b0;
    alu_ctr  = 2'b00;
    alu_srcb = 1'b0;
    ext_op   = 1'b0;
    reg_dst  = 2'b00;
    wd_sel   = 2'b00;
    npc_sel  = 2'b00;
    illegal  = 1'b0;

    case (state_q)
      S_IF: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        case (instr)
          I_ADDU, I_SUBU, I_SLT, I_ORI, I_ADDI: state_d = S_EXE;
          I_LW, I_SW:                           state_d = S_MA;
          I_BEQ:                                state_d = S_BR;
          I_J, I_JAL, I_JR:                     state_d = S_JMP;
          default: begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        endcase
      end

      // Write-back keeps the ALU inputs of execute so alu_out stays valid.
      S_EXE, S_WB: begin
        case (instr)
          I_SUBU, I_SLT: alu_ctr = 2'b01;
          I_ORI: begin
            alu_ctr  = 2'b10;
            alu_srcb = 1'b1;
          end
          I_ADDI: begin
            alu_ctr  = 2'b11;
            alu_srcb = 1'b1;
            ext_op   = 1'b1;
          end
          default: alu_ctr = 2'b00;
        endcase
        if (state_q == S_EXE) begin
          state_d = S_WB;
        end else begin
          // An overflowing addi drops its write but still retires.
          reg_wr  = (instr == I_ADDI) ? ~overflow : 1'b1;
          reg_dst = is_rtype_alu ? 2'b01 : 2'b00;
          wd_sel  = (instr == I_SLT) ? 2'b11 : 2'b00;
          retire  = 1'b1;
          state_d = S_IF;
        end
      end

      // Address computation; the store holds the same address while writing.
      S_MA, S_MW: begin
        alu_ctr  = 2'b00;
        alu_srcb = 1'b1;
        ext_op   = 1'b1;
        if (state_q == S_MW) begin
          dm_wr   = 1'b1;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (instr == I_LW) begin
          state_d = S_MR;
        end else if (instr == I_SW) begin
          state_d = S_MW;
        end else begin
          state_d = S_IF;
        end
      end

      S_MR: begin
        reg_wr  = 1'b1;
        reg_dst = 2'b00;
        wd_sel  = 2'b01;
        retire  = 1'b1;
        state_d = S_IF;
      end

      S_BR: begin
        alu_ctr  = 2'b01;
        alu_srcb = 1'b0;
        npc_sel  = 2'b01;
        pc_wr    = zero;
        retire   = 1'b1;
        state_d  = S_IF;
      end

      S_JMP: begin
        if ((instr == I_J) || (instr == I_JAL)) begin
          pc_wr   = 1'b1;
          npc_sel = 2'b10;
        end
        if (instr == I_JAL) begin
          reg_wr  = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end
        if (instr == I_JR) begin
          npc_sel = 2'b11;
        end
        retire  = 1'b1;
        state_d = S_IF;
      end

      default: state_d = S_IF;
    endcase

    // Reset aborts whatever is in flight: no architectural writes.
    if (rst) begin
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      dm_wr   = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  assign state = state_q;

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      state_q    <= S_IF;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retire_cnt <= retire_cnt + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized instruction streams for mc_ctrl,
// checked cycle by cycle against a per-instruction reference model.
module tb_mc_ctrl;

  localparam int RW = 4;

  // Instruction kinds known to the reference model.
  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_SLT  = 2;
  localparam int K_JR   = 3;
  localparam int K_ORI  = 4;
  localparam int K_ADDI = 5;
  localparam int K_LW   = 6;
  localparam int K_SW   = 7;
  localparam int K_BEQ  = 8;
  localparam int K_J    = 9;
  localparam int K_JAL  = 10;
  localparam int K_BAD  = 11;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       dm_wr;
    logic [1:0] alu_ctr;
    logic       alu_srcb;
    logic       ext_op;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] npc_sel;
    logic       illegal;
  } obs_t;

  logic          clk;
  logic          rst;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          overflow;
  logic          pc_wr;
  logic          ir_wr;
  logic          reg_wr;
  logic          dm_wr;
  logic [1:0]    alu_ctr;
  logic          alu_srcb;
  logic          ext_op;
  logic [1:0]    reg_dst;
  logic [1:0]    wd_sel;
  logic [1:0]    npc_sel;
  logic [3:0]    state;
  logic          illegal;
  logic [RW-1:0] retire_cnt;

  obs_t dut_obs;
  int   n_tests;
  int   n_fail;
  int   exp_retire;

  mc_ctrl #(.RETIRE_W(RW), .REG_RA(5'd31)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .dm_wr(dm_wr),
    .alu_ctr(alu_ctr), .alu_srcb(alu_srcb), .ext_op(ext_op),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel),
    .state(state), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  assign dut_obs = {state, pc_wr, ir_wr, reg_wr, dm_wr, alu_ctr, alu_srcb,
                    ext_op, reg_dst, wd_sel, npc_sel, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return K_ADDU;
      if (fn == 6'b100011) return K_SUBU;
      if (fn == 6'b101010) return K_SLT;
      if (fn == 6'b001000) return K_JR;
      return K_BAD;
    end
    if (op == 6'b001101) return K_ORI;
    if (op == 6'b001000) return K_ADDI;
    if (op == 6'b100011) return K_LW;
    if (op == 6'b101011) return K_SW;
    if (op == 6'b000100) return K_BEQ;
    if (op == 6'b000010) return K_J;
    if (op == 6'b000011) return K_JAL;
    return K_BAD;
  endfunction

  function automatic bit is_alu_kind(input int k);
    return (k == K_ADDU) || (k == K_SUBU) || (k == K_SLT) || (k == K_ORI) || (k == K_ADDI);
  endfunction

  // Number of cycles an instruction occupies, fetch included.
  function automatic int path_len(input int k);
    if (is_alu_kind(k) || k == K_LW || k == K_SW) return 4;
    if (k == K_BAD) return 2;
    return 3;
  endfunction

  // Which state the instruction is in on its s-th cycle.
  function automatic logic [3:0] path_state(input int k, input int s);
    if (s == 0) return 4'd0;
    if (s == 1) return 4'd1;
    if (s == 2) begin
      if (is_alu_kind(k))          return 4'd2;
      if (k == K_LW || k == K_SW)  return 4'd3;
      if (k == K_BEQ)              return 4'd7;
      return 4'd8;
    end
    if (k == K_LW) return 4'd4;
    if (k == K_SW) return 4'd5;
    return 4'd6;
  endfunction

  function automatic obs_t expect_step(input int k, input int s, input logic z, input logic o);
    obs_t e;
    e = '0;
    e.st = path_state(k, s);
    case (e.st)
      4'd0: begin
        e.ir_wr = 1'b1;
        e.pc_wr = 1'b1;
      end
      4'd1: e.illegal = (k == K_BAD);
      4'd2, 4'd6: begin
        e.alu_ctr  = (k == K_ADDU) ? 2'b00 : (k == K_ORI) ? 2'b10 : (k == K_ADDI) ? 2'b11 : 2'b01;
        e.alu_srcb = (k == K_ORI) || (k == K_ADDI);
        e.ext_op   = (k == K_ADDI);
        if (e.st == 4'd6) begin
          e.reg_wr  = (k == K_ADDI) ? ~o : 1'b1;
          e.reg_dst = (k == K_ORI || k == K_ADDI) ? 2'b00 : 2'b01;
          e.wd_sel  = (k == K_SLT) ? 2'b11 : 2'b00;
        end
      end
      4'd3, 4'd5: begin
        e.alu_srcb = 1'b1;
        e.ext_op   = 1'b1;
        e.dm_wr    = (e.st == 4'd5);
      end
      4'd4: begin
        e.reg_wr = 1'b1;
        e.wd_sel = 2'b01;
      end
      4'd7: begin
        e.alu_ctr = 2'b01;
        e.npc_sel = 2'b01;
        e.pc_wr   = z;
      end
      default: begin
        if (k == K_JR) begin
          e.npc_sel = 2'b11;
        end else begin
          e.pc_wr   = 1'b1;
          e.npc_sel = 2'b10;
          if (k == K_JAL) begin
            e.reg_wr  = 1'b1;
            e.reg_dst = 2'b10;
            e.wd_sel  = 2'b10;
          end
        end
      end
    endcase
    return e;
  endfunction

  // Run one instruction from S_IF. zmode/omode: 0 or 1 fixed, 2 random per cycle.
  // abort_at >= 0 raises rst on that cycle and holds it for two edges.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int omode, input int abort_at);
    int   k;
    obs_t e;
    k      = kind_of(op, fn);
    opcode = op;
    funct  = fn;
    for (int s = 0; s < path_len(k); s++) begin
      zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      overflow = (omode == 2) ? 1'($urandom_range(0, 1)) : (omode == 1);
      if (s == abort_at) rst = 1'b1;
      @(negedge clk);
      e = expect_step(k, s, zero, overflow);
      if (s == abort_at) begin
        e.pc_wr   = 1'b0;
        e.ir_wr   = 1'b0;
        e.reg_wr  = 1'b0;
        e.dm_wr   = 1'b0;
        e.illegal = 1'b0;
      end
      check($sformatf("%s.c%0d.out", name, s), 32'(dut_obs), 32'(e));
      check($sformatf("%s.c%0d.retire", name, s), 32'(retire_cnt), 32'(exp_retire));
      @(posedge clk);
      #1;
      if (s == abort_at) begin
        @(negedge clk);
        check($sformatf("%s.rst.out", name), 32'(dut_obs), 32'd0);
        check($sformatf("%s.rst.retire", name), 32'(retire_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        exp_retire = 0;
        return;
      end
    end
    if (k != K_BAD) exp_retire = (exp_retire + 1) % (1 << RW);
  endtask

  logic [5:0] t_op [13];
  logic [5:0] t_fn [13];

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    exp_retire = 0;
    rst        = 1'b1;
    opcode     = 6'b000000;
    funct      = 6'b100001;
    zero       = 1'b0;
    overflow   = 1'b0;

    t_op = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001000,
             6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011, 6'b000000, 6'b111111};
    t_fn = '{6'b100001, 6'b100011, 6'b101010, 6'b001000, 6'b010101, 6'b111111,
             6'b000000, 6'b000100, 6'b000001, 6'b110000, 6'b001111, 6'b000000, 6'b100001};

    // Reset held for two edges: state IF, counter cleared, enables low.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset.out", 32'(dut_obs), 32'd0);
    check("reset.retire", 32'(retire_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed instructions from the test plan.
    run_instr("addu",      6'b000000, 6'b100001, 0, 0, -1);
    run_instr("lw",        6'b100011, 6'b000000, 0, 0, -1);
    run_instr("sw",        6'b101011, 6'b000000, 0, 0, -1);
    run_instr("beq_z1",    6'b000100, 6'b000000, 1, 0, -1);
    run_instr("beq_z0",    6'b000100, 6'b000000, 0, 0, -1);
    run_instr("addi_ov1",  6'b001000, 6'b000000, 0, 1, -1);
    run_instr("addi_ov0",  6'b001000, 6'b000000, 0, 0, -1);
    run_instr("jal",       6'b000011, 6'b000000, 0, 0, -1);
    run_instr("illegal",   6'b111111, 6'b000000, 0, 0, -1);
    run_instr("jr",        6'b000000, 6'b001000, 0, 0, -1);
    run_instr("ori",       6'b001101, 6'b000000, 0, 1, -1);
    run_instr("subu",      6'b000000, 6'b100011, 1, 1, -1);
    run_instr("slt",       6'b000000, 6'b101010, 0, 0, -1);
    run_instr("j",         6'b000010, 6'b000000, 1, 0, -1);
    run_instr("rtype_bad", 6'b000000, 6'b000000, 0, 0, -1);

    // Random stream; the 4-bit counter wraps several times.
    for (int i = 0; i < 80; i++) begin
      int         r;
      logic [5:0] op;
      logic [5:0] fn;
      r = int'($urandom_range(0, 14));
      if (r < 13) begin
        op = t_op[r];
        fn = t_fn[r];
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr($sformatf("rnd%0d", i), op, fn, 2, 2, -1);
    end

    // Reset mid-store in S_MW and mid-decode of an illegal instruction.
    run_instr("sw_abort",  6'b101011, 6'b000000, 0, 0, 3);
    run_instr("ori_after", 6'b001101, 6'b000000, 0, 0, -1);
    run_instr("bad_abort", 6'b111110, 6'b000000, 0, 0, 1);
    run_instr("addu_end",  6'b000000, 6'b100001, 2, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
